// File: rtl/align_inc_pkg.sv
// Shared types and the rounding function for the align_inc_pipe datapath.
// The rounding function works on a fixed MAX_W-bit container so any
// WIDTH up to MAX_W-1 can use it. Callers zero-extend their samples into it.
package align_inc_pkg;

  localparam int MODE_W = 2;
  localparam int MAX_W  = 32;

  typedef enum logic [MODE_W-1:0] {
    MODE_ODD   = 2'b00,
    MODE_EVEN  = 2'b01,
    MODE_ALIGN = 2'b10,
    MODE_PASS  = 2'b11
  } mode_t;

  typedef struct packed {
    logic             ovf;
    logic             adj;
    logic [MAX_W-1:0] data;
  } round_t;

  // Round x up to satisfy mode within a w-bit result. The sum is one bit
  // wider than the container, so anything set at or above bit w is the
  // carry out of the w-bit datapath and marks an overflow.
  function automatic round_t align_round(input logic [MAX_W-1:0] x,
                                         input mode_t            mode,
                                         input int               w,
                                         input int               a,
                                         input logic             sat);
    logic [MAX_W:0] xe;
    logic [MAX_W:0] one;
    logic [MAX_W:0] gran;
    logic [MAX_W:0] low;
    logic [MAX_W:0] full;
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    logic [MAX_W:0] res;
    round_t         r;

    xe   = {1'b0, x};
    one  = {{MAX_W{1'b0}}, 1'b1};
    gran = one << a;
    low  = xe & (gran - one);
    full = (one << w) - one;
    sum  = xe;
    lim  = full;

    case (mode)
      MODE_ODD:   sum = xe[0] ? xe : xe + one;
      MODE_EVEN: begin
        sum = xe[0] ? xe + one : xe;
        lim = full & ~one;
      end
      MODE_ALIGN: begin
        sum = (low != '0) ? xe + gran - low : xe;
        lim = full & ~(gran - one);
      end
      default:    sum = xe;
    endcase

    r.ovf = (sum & ~full) != '0;
    r.adj = (sum != xe);
    if (r.ovf) begin
      res = sat ? lim : (sum & full);
    end else begin
      res = sum;
    end
    r.data = res[MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/align_inc_stage.sv
// Generic valid/ready register slice. Accepts a new payload whenever it is
// empty or its current payload leaves in the same cycle, so a chain of these
// sustains one transfer per cycle and stalls cleanly under backpressure.
module align_inc_stage #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_data
);

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Load on a free slot; hold contents (and valid) while stalled downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/align_inc_pipe.sv
// Two-stage pipelined rounding incrementer with valid/ready on both sides.
// S1 registers the rounded result of each accepted sample, S2 is the output
// register. Optional statistics counter enabled by ALIGN_INC_STATS_EN adds
// the stats_clr / adj_count ports; the datapath is the same either way.
module align_inc_pipe
  import align_inc_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int ALIGN_LOG2 = 2,
  parameter int SATURATE   = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_adj,
  output logic              out_ovf
`ifdef ALIGN_INC_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  adj_count
`endif
);

  localparam int PAY_W = WIDTH + 2;

  round_t           w_rnd;
  logic [PAY_W-1:0] w_pay_p0;
  logic             w_vld_p1;
  logic             w_rdy_p1;
  logic [PAY_W-1:0] w_pay_p1;
  logic             w_vld_p2;
  logic [PAY_W-1:0] w_pay_p2;
  logic             w_unused;

  // Input side: round the offered sample; only loaded into S1 on a transfer.
  assign w_rnd    = align_round(MAX_W'(in_data), mode_t'(in_mode), WIDTH,
                                ALIGN_LOG2, (SATURATE != 0));
  assign w_pay_p0 = {w_rnd.ovf, w_rnd.adj, w_rnd.data[WIDTH-1:0]};
  assign w_unused = &{1'b0, w_rnd.data[MAX_W-1:WIDTH]};

  // ---- stage boundary p0 -> p1: result register
  align_inc_stage #(.PAYLOAD_W(PAY_W)) u_s1 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_pay_p0),
    .o_valid (w_vld_p1),
    .i_ready (w_rdy_p1),
    .o_data  (w_pay_p1)
  );

  // ---- stage boundary p1 -> p2: output register
  align_inc_stage #(.PAYLOAD_W(PAY_W)) u_s2 (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_vld_p1),
    .o_ready (w_rdy_p1),
    .i_data  (w_pay_p1),
    .o_valid (w_vld_p2),
    .i_ready (out_ready),
    .o_data  (w_pay_p2)
  );

  assign out_valid = w_vld_p2;
  assign out_ovf   = w_pay_p2[PAY_W-1];
  assign out_adj   = w_pay_p2[PAY_W-2];
  assign out_data  = w_pay_p2[WIDTH-1:0];

`ifdef ALIGN_INC_STATS_EN
  logic [CNT_W-1:0] r_adj_count;

  // Count adjusted samples taken by the consumer; clear beats increment, saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_adj_count <= '0;
    end else if (stats_clr) begin
      r_adj_count <= '0;
    end else if (out_valid && out_ready && out_adj && (r_adj_count != '1)) begin
      r_adj_count <= r_adj_count + CNT_W'(1);
    end
  end

  assign adj_count = r_adj_count;
`endif

endmodule

// File: tb/tb_align_inc_pipe.sv
// Directed bench for align_inc_pipe (WIDTH=7, ALIGN_LOG2=2). A second
// instance built with SATURATE=0 shares the inputs to cover wrap-around.
// Statistics checks are compiled in when ALIGN_INC_STATS_EN is defined.
module tb_align_inc_pipe;

  localparam logic [1:0] M_ODD   = 2'b00;
  localparam logic [1:0] M_EVEN  = 2'b01;
  localparam logic [1:0] M_ALIGN = 2'b10;
  localparam logic [1:0] M_PASS  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [6:0] in_data;
  logic [1:0] in_mode;
  logic       out_ready;
  logic       stats_clr;

  logic       in_ready,  out_valid,  out_adj,  out_ovf;
  logic [6:0] out_data;
  logic       in_ready2, out_valid2, out_adj2, out_ovf2;
  logic [6:0] out_data2;
  logic [15:0] adj_count, adj_count2;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q[$];
  logic [8:0] q2[$];

  always #5 clk = ~clk;

  align_inc_pipe #(.WIDTH(7), .ALIGN_LOG2(2), .SATURATE(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_adj(out_adj),
    .out_ovf(out_ovf)
`ifdef ALIGN_INC_STATS_EN
    , .stats_clr(stats_clr), .adj_count(adj_count)
`endif
  );

  align_inc_pipe #(.WIDTH(7), .ALIGN_LOG2(2), .SATURATE(0), .CNT_W(16)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_adj(out_adj2),
    .out_ovf(out_ovf2)
`ifdef ALIGN_INC_STATS_EN
    , .stats_clr(stats_clr), .adj_count(adj_count2)
`endif
  );

`ifndef ALIGN_INC_STATS_EN
  assign adj_count  = '0;
  assign adj_count2 = '0;
`endif

  // Record every output transfer that will happen at the coming rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready)  q.push_back({out_ovf, out_adj, out_data});
    if (out_valid2 && out_ready) q2.push_back({out_ovf2, out_adj2, out_data2});
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one sample until it is accepted (bounded).
  task automatic push(input logic [6:0] d, input logic [1:0] m);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL push_timeout data=%0d in_ready=%b required 1", d, in_ready);
    end
  endtask

  // Wait (bounded) until n transfers were recorded, plus a few idle cycles.
  task automatic drain(input int n);
    for (int i = 0; i < 60 && q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 7'd0) begin failures++; $display("FAIL rst_data got=%0d want=0", out_data); end
    checks++; if ({out_adj, out_ovf} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b want=00", {out_adj, out_ovf}); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_odd;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 7'd4;
    in_mode   = M_ODD;
    @(posedge clk); #1;
    in_data = 7'd5;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL odd_lat1 out_valid got=%b want=0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL odd_lat2 out_valid got=%b want=1", out_valid); end
    checks++; if ({out_ovf, out_adj, out_data} !== {1'b0, 1'b1, 7'd5}) begin
      failures++; $display("FAIL odd_first got=%0d adj=%b ovf=%b want=5 adj=1 ovf=0", out_data, out_adj, out_ovf);
    end
    @(posedge clk); #1;
    checks++; if ({out_valid, out_ovf, out_adj, out_data} !== {1'b1, 1'b0, 1'b0, 7'd5}) begin
      failures++; $display("FAIL odd_second valid=%b got=%0d adj=%b want valid=1 5 adj=0", out_valid, out_data, out_adj);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL odd_empty out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_even_ovf;
    q.delete(); q2.delete();
    out_ready = 1'b1;
    push(7'd127, M_EVEN);
    push(7'd6, M_EVEN);
    push(7'd3, M_EVEN);
    drain(3);
    checks++; if (q.size() != 3) begin failures++; $display("FAIL even_count got=%0d want=3", q.size()); end
    checks++; if (q[0] !== {1'b1, 1'b1, 7'd126}) begin failures++; $display("FAIL even_sat127 got=%h want=%h", q[0], {1'b1, 1'b1, 7'd126}); end
    checks++; if (q[1] !== {1'b0, 1'b0, 7'd6}) begin failures++; $display("FAIL even_keep6 got=%h want=%h", q[1], {1'b0, 1'b0, 7'd6}); end
    checks++; if (q[2] !== {1'b0, 1'b1, 7'd4}) begin failures++; $display("FAIL even_3to4 got=%h want=%h", q[2], {1'b0, 1'b1, 7'd4}); end
    checks++; if (q2[0] !== {1'b1, 1'b1, 7'd0}) begin failures++; $display("FAIL even_wrap127 got=%h want=%h", q2[0], {1'b1, 1'b1, 7'd0}); end
  endtask

  task automatic test_align;
    q.delete(); q2.delete();
    out_ready = 1'b1;
    push(7'd9, M_ALIGN);
    push(7'd12, M_ALIGN);
    push(7'd125, M_ALIGN);
    push(7'd33, M_PASS);
    drain(4);
    checks++; if (q.size() != 4) begin failures++; $display("FAIL align_count got=%0d want=4", q.size()); end
    checks++; if (q[0] !== {1'b0, 1'b1, 7'd12}) begin failures++; $display("FAIL align_9 got=%h want=%h", q[0], {1'b0, 1'b1, 7'd12}); end
    checks++; if (q[1] !== {1'b0, 1'b0, 7'd12}) begin failures++; $display("FAIL align_12 got=%h want=%h", q[1], {1'b0, 1'b0, 7'd12}); end
    checks++; if (q[2] !== {1'b1, 1'b1, 7'd124}) begin failures++; $display("FAIL align_sat125 got=%h want=%h", q[2], {1'b1, 1'b1, 7'd124}); end
    checks++; if (q[3] !== {1'b0, 1'b0, 7'd33}) begin failures++; $display("FAIL pass_33 got=%h want=%h", q[3], {1'b0, 1'b0, 7'd33}); end
    checks++; if (q2[2] !== {1'b1, 1'b1, 7'd0}) begin failures++; $display("FAIL align_wrap125 got=%h want=%h", q2[2], {1'b1, 1'b1, 7'd0}); end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp_d [10] = '{7'd1, 7'd3, 7'd3, 7'd5, 7'd5, 7'd7, 7'd7, 7'd9, 7'd9, 7'd11};
    logic       exp_a [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0] held;
    q.delete(); q2.delete();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 10; i++) push(7'(i), M_ODD);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        held = {out_ovf, out_adj, out_data};
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        checks++; if ({out_valid, out_ovf, out_adj, out_data} !== {1'b1, held}) begin
          failures++; $display("FAIL bp_hold got=%b_%h want=1_%h", out_valid, {out_ovf, out_adj, out_data}, held);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain(10);
    checks++; if (q.size() != 10) begin failures++; $display("FAIL bp_count got=%0d want=10", q.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (q[i] !== {1'b0, exp_a[i], exp_d[i]}) begin
        failures++; $display("FAIL bp_item%0d got=%h want=%h", i, q[i], {1'b0, exp_a[i], exp_d[i]});
      end
    end
  endtask

  task automatic test_reset_midflight;
    q.delete(); q2.delete();
    out_ready = 1'b0;
    push(7'd2, M_ODD);
    push(7'd4, M_ODD);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%b want=1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b want=0", out_valid); end
    checks++; if ({out_data, out_adj, out_ovf} !== 9'd0) begin
      failures++; $display("FAIL mid_async_out got=%h want=0", {out_data, out_adj, out_ovf});
    end
`ifdef ALIGN_INC_STATS_EN
    checks++; if (adj_count !== 16'd0) begin failures++; $display("FAIL mid_async_cnt got=%0d want=0", adj_count); end
`endif
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (q.size() != 0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL mid_no_leak got=%0d items valid=%b want=0 items valid=0", q.size(), out_valid);
    end
  endtask

`ifdef ALIGN_INC_STATS_EN
  task automatic test_stats;
    q.delete(); q2.delete();
    out_ready = 1'b1;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    checks++; if (adj_count !== 16'd0) begin failures++; $display("FAIL stats_clr0 got=%0d want=0", adj_count); end
    push(7'd0, M_ODD);  push(7'd1, M_ODD); push(7'd2, M_ODD);
    push(7'd3, M_ODD);  push(7'd4, M_ODD); push(7'd5, M_ODD);
    push(7'd6, M_ODD);  push(7'd8, M_ODD); push(7'd10, M_ODD);
    drain(9);
    checks++; if (adj_count !== 16'd6) begin failures++; $display("FAIL stats_count got=%0d want=6", adj_count); end
    out_ready = 1'b0;
    push(7'd12, M_ODD);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    stats_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    checks++; if (adj_count !== 16'd0) begin failures++; $display("FAIL stats_clr_wins got=%0d want=0", adj_count); end
    checks++; if (q.size() != 10) begin failures++; $display("FAIL stats_deliveries got=%0d want=10", q.size()); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = M_ODD;
    out_ready = 1'b1;
    stats_clr = 1'b0;
    test_reset();
    test_odd();
    test_even_ovf();
    test_align();
    test_back_to_back();
    test_reset_midflight();
`ifdef ALIGN_INC_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
